// File: rtl/vec_lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vec_lsu_pkg
// Description : Shared vector load/store types: FSM states, SEW encodings,
//               byte-strobe base patterns and an alignment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package vec_lsu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } lsu_state_t;

   localparam logic [6:0] c_sew_8  = 7'd8;
   localparam logic [6:0] c_sew_16 = 7'd16;
   localparam logic [6:0] c_sew_32 = 7'd32;

   localparam logic [3:0] c_strb_b8  = 4'b0001;
   localparam logic [3:0] c_strb_b16 = 4'b0011;
   localparam logic [3:0] c_strb_b32 = 4'b1111;

   function automatic logic sew_misaligned(input logic [6:0] sew, input logic [1:0] off);
      case (sew)
         c_sew_16: return off[0];
         c_sew_32: return (off != 2'b00);
         default:  return 1'b0;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/vec_store_align.sv
`default_nettype none
// ============================================================================
// Module      : vec_store_align
// Description : Places one store element into its byte lane of the memory
//               word and produces the matching strobes and misalignment flag.
// Revision    : 1.0 - initial release
// ============================================================================
module vec_store_align
   import vec_lsu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0]   i_elem,
   input  logic [6:0]        i_sew,
   input  logic [1:0]        i_off,
   output logic [XLEN-1:0]   o_data,
   output logic [XLEN/8-1:0] o_strb,
   output logic              o_misaligned
);
   localparam int SB_W = XLEN / 8;

   logic [XLEN-1:0] w_elem_zx;

   always_comb begin
      w_elem_zx = '0;
      o_strb    = '0;
      case (i_sew)
         c_sew_8: begin
            w_elem_zx = {{(XLEN-8){1'b0}}, i_elem[7:0]};
            o_strb    = SB_W'(c_strb_b8) << i_off;
         end
         c_sew_16: begin
            w_elem_zx = {{(XLEN-16){1'b0}}, i_elem[15:0]};
            o_strb    = SB_W'(c_strb_b16) << i_off;
         end
         c_sew_32: begin
            w_elem_zx = i_elem;
            o_strb    = SB_W'(c_strb_b32);
         end
         default: ;
      endcase
      o_data       = w_elem_zx << {i_off, 3'b000};
      o_misaligned = sew_misaligned(i_sew, i_off);
   end

endmodule
`default_nettype wire

// File: rtl/vec_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : vec_store_unit
// Description : Unit-stride/strided vector store engine issuing one memory
//               write per active element over a req/ack handshake.
//               Define VEC_STORE_MASK_EN to honour vm/v0 element masking.
// Revision    : 1.0 - initial release
// ============================================================================
module vec_store_unit
   import vec_lsu_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int MAX_VLEN = 512,
   parameter int MAX_ELEM = MAX_VLEN / 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                stride_sel,
   input  logic [XLEN-1:0]     base_addr,
   input  logic [XLEN-1:0]     stride,
   input  logic [6:0]          sew,
   input  logic [XLEN-1:0]     vl,
   input  logic [MAX_VLEN-1:0] vs3_data,
   input  logic                vm,
   input  logic [MAX_ELEM-1:0] v0_mask_data,
   input  logic                st_ack,
   output logic                st_req,
   output logic [XLEN-1:0]     lsu2mem_addr,
   output logic [XLEN-1:0]     lsu2mem_data,
   output logic [XLEN/8-1:0]   wr_strb,
   output logic                busy,
   output logic                is_stored,
   output logic                store_err
);
   localparam int IDX_W  = $clog2(MAX_ELEM + 1);
   localparam int SH_W   = IDX_W + 7;
   localparam int SB_W   = XLEN / 8;
   localparam int MASK_W = 1 << IDX_W;

   lsu_state_t          r_state;
   logic [IDX_W-1:0]    r_index, r_n;
   logic [XLEN-1:0]     r_addr, r_stride;
   logic [6:0]          r_sew;
   logic [MAX_VLEN-1:0] r_vs3;
   logic                r_st_req, r_busy, r_is_stored, r_store_err;
   logic [XLEN-1:0]     r_bus_addr, r_bus_data;
   logic [SB_W-1:0]     r_bus_strb;

   logic                w_idle, w_sew_ok, w_last, w_cur_active, w_nxt_active, w_nxt_mis;
   logic [XLEN-1:0]     w_cap, w_nxt_addr, w_nxt_data, w_elem;
   logic [IDX_W-1:0]    w_n, w_nxt_index;
   logic [6:0]          w_src_sew;
   logic [SH_W-1:0]     w_shamt;
   logic [MAX_VLEN-1:0] w_src_vs3, w_shifted;
   logic [SB_W-1:0]     w_nxt_strb;

   always_comb begin
      w_cap    = '0;
      w_sew_ok = 1'b1;
      case (sew)
         c_sew_8:  w_cap = XLEN'(MAX_ELEM);
         c_sew_16: w_cap = XLEN'(MAX_ELEM / 2);
         c_sew_32: w_cap = XLEN'(MAX_ELEM / 4);
         default:  w_sew_ok = 1'b0;
      endcase
   end

   assign w_n    = (vl < w_cap) ? vl[IDX_W-1:0] : w_cap[IDX_W-1:0];
   assign w_idle = (r_state == IDLE);
   assign w_last = (r_index == r_n - IDX_W'(1));

   // Outputs are registered, so the bus is always loaded with the element
   // that will be current after this edge: element 0 from the live inputs
   // when starting, otherwise the successor of the latched element.
   assign w_src_vs3   = w_idle ? vs3_data : r_vs3;
   assign w_src_sew   = w_idle ? sew : r_sew;
   assign w_nxt_index = w_idle ? '0 : r_index + IDX_W'(1);
   assign w_nxt_addr  = w_idle ? base_addr : r_addr + r_stride;
   assign w_shamt     = SH_W'(w_nxt_index) * SH_W'(w_src_sew);
   assign w_shifted   = w_src_vs3 >> w_shamt;
   assign w_elem      = w_shifted[XLEN-1:0];

   vec_store_align #(
      .XLEN (XLEN)
   ) u_align (
      .i_elem       (w_elem),
      .i_sew        (w_src_sew),
      .i_off        (w_nxt_addr[1:0]),
      .o_data       (w_nxt_data),
      .o_strb       (w_nxt_strb),
      .o_misaligned (w_nxt_mis)
   );

`ifdef VEC_STORE_MASK_EN
   logic              r_mask_on;
   logic [MASK_W-1:0] r_v0;

   assign w_cur_active = !r_mask_on || r_v0[r_index];
   assign w_nxt_active = w_idle ? (vm || v0_mask_data[0]) : (!r_mask_on || r_v0[w_nxt_index]);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mask_on <= 1'b0;
         r_v0      <= '0;
      end else if (w_idle && start) begin
         r_mask_on <= !vm;
         r_v0      <= {{(MASK_W-MAX_ELEM){1'b0}}, v0_mask_data};
      end
   end
`else
   logic w_unused_mask;
   assign w_unused_mask = ^{vm, v0_mask_data};
   assign w_cur_active  = 1'b1;
   assign w_nxt_active  = 1'b1;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_index     <= '0;
         r_n         <= '0;
         r_addr      <= '0;
         r_stride    <= '0;
         r_sew       <= '0;
         r_vs3       <= '0;
         r_st_req    <= 1'b0;
         r_busy      <= 1'b0;
         r_is_stored <= 1'b0;
         r_store_err <= 1'b0;
         r_bus_addr  <= '0;
         r_bus_data  <= '0;
         r_bus_strb  <= '0;
      end else begin
         r_is_stored <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_sew       <= sew;
                  r_vs3       <= vs3_data;
                  r_n         <= w_n;
                  r_stride    <= stride_sel ? stride : XLEN'(sew >> 3);
                  r_index     <= '0;
                  r_addr      <= base_addr;
                  r_busy      <= 1'b1;
                  r_store_err <= 1'b0;
                  if (!w_sew_ok || (w_n == '0)) begin
                     r_state     <= DONE;
                     r_is_stored <= 1'b1;
                     r_store_err <= !w_sew_ok;
                  end else begin
                     r_state    <= REQ;
                     r_st_req   <= w_nxt_active && !w_nxt_mis;
                     r_bus_addr <= w_nxt_addr;
                     r_bus_data <= w_nxt_data;
                     r_bus_strb <= w_nxt_strb;
                  end
               end
            end
            REQ: begin
               // With no request raised, an active element can only be misaligned.
               if ((r_st_req && st_ack) || (!r_st_req && !w_cur_active)) begin
                  if (w_last) begin
                     r_state     <= DONE;
                     r_st_req    <= 1'b0;
                     r_is_stored <= 1'b1;
                  end else begin
                     r_index    <= w_nxt_index;
                     r_addr     <= w_nxt_addr;
                     r_st_req   <= w_nxt_active && !w_nxt_mis;
                     r_bus_addr <= w_nxt_addr;
                     r_bus_data <= w_nxt_data;
                     r_bus_strb <= w_nxt_strb;
                  end
               end else if (!r_st_req) begin
                  r_state     <= DONE;
                  r_is_stored <= 1'b1;
                  r_store_err <= 1'b1;
               end
            end
            DONE: begin
               r_state     <= IDLE;
               r_busy      <= 1'b0;
               r_store_err <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign st_req       = r_st_req;
   assign lsu2mem_addr = r_bus_addr;
   assign lsu2mem_data = r_bus_data;
   assign wr_strb      = r_bus_strb;
   assign busy         = r_busy;
   assign is_stored    = r_is_stored;
   assign store_err    = r_store_err;

endmodule
`default_nettype wire

// File: tb/tb_vec_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_vec_store_unit
// Description : Directed self-checking bench for vec_store_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vec_store_unit;
   logic         clk = 1'b0;
   logic         reset, start, stride_sel, vm, st_ack;
   logic [31:0]  base_addr, stride, vl;
   logic [6:0]   sew;
   logic [511:0] vs3_data;
   logic [63:0]  v0_mask_data;
   logic         st_req, busy, is_stored, store_err;
   logic [31:0]  lsu2mem_addr, lsu2mem_data;
   logic [3:0]   wr_strb;

   int          tests = 0;
   int          fails = 0;
   int          nwr, done_cyc, stable_bad, seen_stored;
   logic        done_err;
   logic [31:0] wa [0:127];
   logic [31:0] wd [0:127];
   logic [3:0]  ws [0:127];

   always #5 clk = ~clk;

   vec_store_unit #(.XLEN(32), .MAX_VLEN(512), .MAX_ELEM(64)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .stride_sel   (stride_sel),
      .base_addr    (base_addr),
      .stride       (stride),
      .sew          (sew),
      .vl           (vl),
      .vs3_data     (vs3_data),
      .vm           (vm),
      .v0_mask_data (v0_mask_data),
      .st_ack       (st_ack),
      .st_req       (st_req),
      .lsu2mem_addr (lsu2mem_addr),
      .lsu2mem_data (lsu2mem_data),
      .wr_strb      (wr_strb),
      .busy         (busy),
      .is_stored    (is_stored),
      .store_err    (store_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic setup(input logic sel, input logic [31:0] base, input logic [31:0] strd,
                        input logic [6:0] sw, input logic [31:0] len);
      stride_sel = sel;
      base_addr  = base;
      stride     = strd;
      sew        = sw;
      vl         = len;
      vm         = 1'b1;
      v0_mask_data = '0;
      vs3_data   = '0;
   endtask

   // Called at posedge+1 in IDLE; start is presented in cycle 0.
   task automatic do_store(input int ack_delay, input bit poke_start);
      int cyc;
      int wait_cnt;
      nwr = 0; done_cyc = -1; done_err = 1'bx; stable_bad = 0; wait_cnt = 0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 1;
      while (cyc < 400) begin
         st_ack = 1'b0;
         if (is_stored) begin
            done_cyc = cyc;
            done_err = store_err;
            break;
         end
         if (st_req && nwr < 128) begin
            if (wait_cnt == 0) begin
               wa[nwr] = lsu2mem_addr; wd[nwr] = lsu2mem_data; ws[nwr] = wr_strb;
            end else if (wa[nwr] !== lsu2mem_addr || wd[nwr] !== lsu2mem_data || ws[nwr] !== wr_strb) begin
               stable_bad++;
            end
            if (wait_cnt == ack_delay) begin
               st_ack = 1'b1; nwr++; wait_cnt = 0;
            end else begin
               wait_cnt++;
            end
         end
         if (poke_start) start = 1'b1;
         @(posedge clk); #1;
         cyc++;
      end
      start  = 1'b0;
      st_ack = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; st_ack = 1'b0;
      setup(1'b0, 32'h0, 32'h0, 7'd32, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      check("rst_st_req", 32'(st_req), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_is_stored", 32'(is_stored), 32'h0);
      check("rst_store_err", 32'(store_err), 32'h0);
      check("rst_addr", lsu2mem_addr, 32'h0);
      check("rst_data", lsu2mem_data, 32'h0);
      check("rst_strb", 32'(wr_strb), 32'h0);
      reset = 1'b0;
      @(posedge clk); #1;

      // Stray ack while idle
      st_ack = 1'b1;
      @(posedge clk); #1;
      st_ack = 1'b0;
      check("idle_ack_busy", 32'(busy), 32'h0);

      // Unit stride SEW32
      setup(1'b0, 32'h100, 32'h0, 7'd32, 32'd4);
      for (int i = 0; i < 4; i++) vs3_data[i*32 +: 32] = 32'hC0DE_0000 | 32'(i);
      do_store(0, 1'b0);
      check("u32_nwr", 32'(nwr), 32'd4);
      for (int i = 0; i < 4; i++) begin
         check("u32_addr", wa[i], 32'h100 + 32'(4*i));
         check("u32_data", wd[i], 32'hC0DE_0000 | 32'(i));
         check("u32_strb", 32'(ws[i]), 32'hF);
      end
      check("u32_done_cyc", 32'(done_cyc), 32'd5);
      check("u32_err", 32'(done_err), 32'h0);

      // Strided SEW8, stride -1
      setup(1'b1, 32'h203, 32'hFFFF_FFFF, 7'd8, 32'd3);
      vs3_data[7:0] = 8'h5A; vs3_data[15:8] = 8'h6B; vs3_data[23:16] = 8'h7C;
      do_store(0, 1'b0);
      check("s8_nwr", 32'(nwr), 32'd3);
      check("s8_addr0", wa[0], 32'h203);
      check("s8_data0", wd[0], 32'h5A00_0000);
      check("s8_strb0", 32'(ws[0]), 32'h8);
      check("s8_addr1", wa[1], 32'h202);
      check("s8_data1", wd[1], 32'h006B_0000);
      check("s8_strb1", 32'(ws[1]), 32'h4);
      check("s8_addr2", wa[2], 32'h201);
      check("s8_data2", wd[2], 32'h0000_7C00);
      check("s8_strb2", 32'(ws[2]), 32'h2);
      check("s8_done_cyc", 32'(done_cyc), 32'd4);

      // Masked SEW16, v0 = 0101
      setup(1'b0, 32'h400, 32'h0, 7'd16, 32'd4);
      vm = 1'b0; v0_mask_data = 64'b0101;
      vs3_data[63:0] = 64'h4444_3333_2222_1111;
      do_store(0, 1'b0);
`ifdef VEC_STORE_MASK_EN
      check("m16_nwr", 32'(nwr), 32'd2);
      check("m16_addr0", wa[0], 32'h400);
      check("m16_data0", wd[0], 32'h0000_1111);
      check("m16_addr1", wa[1], 32'h404);
      check("m16_data1", wd[1], 32'h0000_3333);
      check("m16_strb1", 32'(ws[1]), 32'h3);
`else
      check("m16_nwr", 32'(nwr), 32'd4);
      check("m16_addr1", wa[1], 32'h402);
      check("m16_data1", wd[1], 32'h2222_0000);
      check("m16_strb1", 32'(ws[1]), 32'hC);
      check("m16_addr3", wa[3], 32'h406);
      check("m16_data3", wd[3], 32'h4444_0000);
`endif
      check("m16_done_cyc", 32'(done_cyc), 32'd5);

      // Misaligned SEW32
      setup(1'b0, 32'h102, 32'h0, 7'd32, 32'd4);
      do_store(0, 1'b0);
      check("mis_nwr", 32'(nwr), 32'd0);
      check("mis_done_cyc", 32'(done_cyc), 32'd2);
      check("mis_err", 32'(done_err), 32'h1);

      // Illegal SEW
      setup(1'b0, 32'h100, 32'h0, 7'd64, 32'd4);
      do_store(0, 1'b0);
      check("sew64_done_cyc", 32'(done_cyc), 32'd1);
      check("sew64_err", 32'(done_err), 32'h1);

      // vl = 0
      setup(1'b0, 32'h100, 32'h0, 7'd32, 32'd0);
      do_store(0, 1'b0);
      check("vl0_done_cyc", 32'(done_cyc), 32'd1);
      check("vl0_err", 32'(done_err), 32'h0);

      // Backpressure with start pokes while busy
      setup(1'b0, 32'h10, 32'h0, 7'd16, 32'd3);
      vs3_data[47:0] = 48'hCCC3_BBB2_AAA1;
      do_store(3, 1'b1);
      check("bp_stable", 32'(stable_bad), 32'd0);
      check("bp_nwr", 32'(nwr), 32'd3);
      check("bp_addr1", wa[1], 32'h12);
      check("bp_data1", wd[1], 32'hBBB2_0000);
      check("bp_strb1", 32'(ws[1]), 32'hC);
      check("bp_addr2", wa[2], 32'h14);
      check("bp_data2", wd[2], 32'h0000_CCC3);
      check("bp_done_cyc", 32'(done_cyc), 32'd13);

      // vl clamp at SEW8
      setup(1'b0, 32'h800, 32'h0, 7'd8, 32'd1000);
      for (int i = 0; i < 64; i++) vs3_data[i*8 +: 8] = 8'(i + 1);
      do_store(0, 1'b0);
      check("clamp_nwr", 32'(nwr), 32'd64);
      check("clamp_data5", wd[5], 32'h0000_0600);
      check("clamp_strb5", 32'(ws[5]), 32'h2);
      check("clamp_addr63", wa[63], 32'h83F);
      check("clamp_data63", wd[63], 32'h4000_0000);
      check("clamp_strb63", 32'(ws[63]), 32'h8);
      check("clamp_done_cyc", 32'(done_cyc), 32'd65);

      // Reset during element 2
      setup(1'b0, 32'h100, 32'h0, 7'd32, 32'd4);
      for (int i = 0; i < 4; i++) vs3_data[i*32 +: 32] = 32'hBEEF_0000 | 32'(i);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      st_ack = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("rmid_addr_e2", lsu2mem_addr, 32'h108);
      check("rmid_req_e2", 32'(st_req), 32'h1);
      st_ack = 1'b0;
      reset  = 1'b1;
      #1;
      check("rmid_st_req", 32'(st_req), 32'h0);
      check("rmid_busy", 32'(busy), 32'h0);
      check("rmid_addr", lsu2mem_addr, 32'h0);
      check("rmid_data", lsu2mem_data, 32'h0);
      check("rmid_strb", 32'(wr_strb), 32'h0);
      @(posedge clk); #1;
      reset = 1'b0;
      seen_stored = 0;
      for (int i = 0; i < 4; i++) begin
         if (is_stored) seen_stored++;
         @(posedge clk); #1;
      end
      check("rmid_no_stored", 32'(seen_stored), 32'd0);
      do_store(0, 1'b0);
      check("rerun_nwr", 32'(nwr), 32'd4);
      check("rerun_addr0", wa[0], 32'h100);
      check("rerun_data0", wd[0], 32'hBEEF_0000);
      check("rerun_done_cyc", 32'(done_cyc), 32'd5);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
